execute_mc: RTL and testbench
=============================

Name: execute_mc

Overview:
Parametrised, multi-cycle successor of the single-cycle execute stage. It sits after decode and register read and performs ALU, shift, compare, multiply, data-memory and branch operations. Data width is generic. New shift, compare and iterative-multiply operations are added, and a stall handshake back to decode covers the multi-cycle multiply. The status register gains a negative flag and real carry/borrow semantics.

Parameters:
DATA_W, 8, operand/result/memory-data width (≥4)
ADDR_W, 12, data-memory address width
SEL_W, 2, register-select width
MUL_EN, 1, 1 = MUL implemented; 0 = MUL executes as NOP (no stall)

Ports:
clk  in  1  clock
reset_  in  1  reset, synchronous, active-high (asserted = 1)
print_en  in  1  enables debug $display
cycle_counter  in  32  cycle count for debug prints
execute_en  in  1  stage-0 op valid
exec_ctrl  in  4  stage-0 opcode (execute_pkg encoding)
dst_reg  in  SEL_W  destination register, stage 0
dst_addr  in  ADDR_W  memory address, stage 0
reg_src0_data  in  DATA_W  operand A, valid in stage 1
reg_src1_data  in  DATA_W  operand B, valid in stage 1
imm_data  in  DATA_W  immediate, valid in stage 1
imm_data_vld  in  1  selects imm_data over reg_src1_data as operand B
reg_wr_data  out  DATA_W  writeback data
reg_wr_sel  out  SEL_W  writeback register
reg_wr_en  out  1  writeback strobe
d_mem_addr  out  ADDR_W  memory address
d_mem_data_out  out  DATA_W  store data (= operand A)
d_mem_data_in  in  DATA_W  load data, same cycle as d_mem_rd
d_mem_en / d_mem_rd / d_mem_wr  out  1 each  memory strobes
pc_branch  out  1  jump taken
stall  out  1  execute busy; upstream holds stage-0 inputs
sr  out  8  status register

Behaviour:
- Reset is synchronous and active-high; it applies only on a clk edge with reset_ = 1.
- Reset state: stage-1 regs = NOP / disabled; sr = 0; multiply counter idle; stall = 0.
- Consequence of reset: all strobes (reg_wr_en, d_mem_*, pc_branch) are 0 the cycle after reset.
- Two stages: stage 0 = inputs; stage 1 = registered exec_ctrl, execute_en, dst_reg, dst_addr.
- Stage-1 registers load only when stall = 0.
- Operands are sampled in stage 1. Single-cycle ops produce writeback combinationally in stage 1 (latency 1).
- pc_branch = (exec_ctrl == JMP) & execute_en & !stall, combinational from stage 0.
- Memory: d_mem_rd/d_mem_wr assert in stage 1 for MEM_RD/MEM_WR. d_mem_en = rd | wr. MEM_RD writes d_mem_data_in to dst_reg.
- Flags, sr bits: 0 C/OVF, 1 ST-OVF (held 0), 2 NZ, 3 Z, 4 I/TRP (preserved, never written here), 5 N (= result MSB), 7:6 zero.
- ADD: C = carry out.
- SUB: C = borrow.
- CMP: same as SUB but no reg write.
- OR/AND/XOR: C = 0.
- SHL: C = bit shifted out of the MSB.
- SHR: logical shift; C = bit shifted out of the LSB.
- MUL: C = OR of the high DATA_W bits of the product.
- JMP/CALL/RET: clear bits 3:0 and 5.
- NOP/MEM_*: sr unchanged.
- Flags update on the cycle the result is written.
- MUL state machine, IDLE→BUSY→DONE:
  - IDLE→BUSY when stage 1 holds a valid MUL: operands latched; stall = 1 from that cycle.
  - BUSY: one shift-add iteration per cycle; BUSY lasts DATA_W cycles total.
  - DONE: stall = 0; reg_wr_en = 1 with the low DATA_W product bits; sr updated.
  - Stall is therefore high exactly DATA_W cycles, and writeback occurs DATA_W+1 cycles after stage-1 entry.
- Boundary rules:
  - execute_en dropping mid-MUL is ignored.
  - Reset mid-MUL aborts: no writeback; stall low after the reset edge.
  - A stage-0 JMP during stall is not taken until stall drops.
  - Back-to-back MULs insert no idle cycle beyond DONE.
  - All arithmetic is modulo 2^DATA_W.

Decomposition:
- execute_pkg holds:
  - opcodes: NOP 0, ADD 1, SUB 2, OR 3, AND 4, XOR 5, MEM_RD 6, MEM_WR 7, JMP 8, CALL 9, RET 10, SHL 11, SHR 12, MUL 13, CMP 14
  - SR bit-index constants
  - MUL FSM state encodings
- One sub-module: mul_seq (iterative shift-add multiplier with start/busy/done, DATA_W-parametrised).

Test Plan:
- ADD, operand A 8'hF0 + imm 8'h20 → reg_wr_data 8'h10, reg_wr_en 1 in the stage-1 cycle, sr 8'h05.
- SUB 8'h05 − 8'h05 → reg_wr_data 8'h00, sr 8'h08. CMP 8'h03 vs 8'h05 → reg_wr_en 0, sr 8'h25.
- MUL 8'h10 × 8'h11 → stall high exactly 8 cycles, then reg_wr_data 8'h10, sr 8'h05. A JMP presented during stall gives pc_branch 0 until stall falls.
- Reset (reset_ = 1) during the 3rd MUL busy cycle → no reg_wr_en; stall 0 and sr 8'h00 next cycle.
- MEM_WR with operand A 8'hA5 to dst_addr 12'h123 → d_mem_wr/d_mem_en 1 for one cycle, d_mem_data_out 8'hA5, sr unchanged.
- MEM_RD with d_mem_in 8'h3C → reg_wr_data 8'h3C, reg_wr_en 1.
- DATA_W = 16: MUL 16'h1234 × 16'h0100 → stall 16 cycles, reg_wr_data 16'h3400, C = 1.
- SHR 16'h0001 → result 0, sr 8'h09.

Source files
------------

// File: rtl/execute_pkg.sv
// Shared definitions for the multi-cycle execute stage: opcodes, status
// register bit positions and multiplier sequencer states.
package execute_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_ADD    = 4'd1,
    OP_SUB    = 4'd2,
    OP_OR     = 4'd3,
    OP_AND    = 4'd4,
    OP_XOR    = 4'd5,
    OP_MEM_RD = 4'd6,
    OP_MEM_WR = 4'd7,
    OP_JMP    = 4'd8,
    OP_CALL   = 4'd9,
    OP_RET    = 4'd10,
    OP_SHL    = 4'd11,
    OP_SHR    = 4'd12,
    OP_MUL    = 4'd13,
    OP_CMP    = 4'd14
  } op_e;

  // Status register bit positions; bits 7:6 always read zero.
  localparam int SR_C     = 0;  // carry / borrow / multiply overflow
  localparam int SR_STOVF = 1;  // stack overflow, held 0 in this stage
  localparam int SR_NZ    = 2;  // result non-zero
  localparam int SR_Z     = 3;  // result zero
  localparam int SR_TRP   = 4;  // interrupt/trap, owned elsewhere
  localparam int SR_N     = 5;  // result MSB

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/execute_mc_if.sv
// Data-memory bus between the execute stage (master) and data memory (slave).
// Load data is returned combinationally in the same cycle as d_mem_rd.
interface execute_mc_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] d_mem_addr;
  logic [DATA_W-1:0] d_mem_data_out;
  logic [DATA_W-1:0] d_mem_data_in;
  logic              d_mem_en;
  logic              d_mem_rd;
  logic              d_mem_wr;

  modport master (
    output d_mem_addr, d_mem_data_out, d_mem_en, d_mem_rd, d_mem_wr,
    input  d_mem_data_in
  );

  modport slave (
    input  d_mem_addr, d_mem_data_out, d_mem_en, d_mem_rd, d_mem_wr,
    output d_mem_data_in
  );
endinterface

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier. The start edge latches the operands and
// performs the first partial-product step, then BUSY performs the remaining
// DATA_W-1 steps, so busy is high for exactly DATA_W cycles and the full
// 2*DATA_W-bit product is presented in the DONE cycle.
module mul_seq
  import execute_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product,
  output mul_state_e            state
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;

  // Sequencer: operand latch plus one shift-add step per clock.
  always_ff @(posedge clk) begin
    if (reset_) begin
      state   <= MUL_IDLE;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            product <= b[0] ? {{DATA_W{1'b0}}, a} : '0;
            mcand   <= {{(DATA_W-1){1'b0}}, a, 1'b0};
            mplier  <= b >> 1;
            cnt     <= CNT_W'(1);
            state   <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (mplier[0]) product <= product + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state <= MUL_DONE;
        end
        MUL_DONE: state <= MUL_IDLE;
        default:  state <= MUL_IDLE;
      endcase
    end
  end

  // The start cycle itself already counts as busy so upstream holds at once.
  assign busy = (start && (state == MUL_IDLE)) || (state == MUL_BUSY);
  assign done = (state == MUL_DONE);

endmodule

// File: rtl/execute_mc.sv
// Two-stage execute: stage 0 is the raw decode inputs, stage 1 holds the
// registered opcode/enable/destination while operands arrive from register
// read. Single-cycle ops write back combinationally in stage 1; MUL runs on
// the iterative sequencer and writes back in its DONE cycle.
//
// Stall handshake: while stall = 1 decode must hold its stage-0 inputs and
// the register-read operands for the op in stage 1; the stage-1 registers
// only capture stage 0 on a clock edge where stall = 0, so an op is accepted
// exactly on an edge with stall low.
module execute_mc
  import execute_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int SEL_W  = 2,
  parameter bit MUL_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic               print_en,
  input  logic [31:0]        cycle_counter,
  input  logic               execute_en,
  input  logic [3:0]         exec_ctrl,
  input  logic [SEL_W-1:0]   dst_reg,
  input  logic [ADDR_W-1:0]  dst_addr,
  input  logic [DATA_W-1:0]  reg_src0_data,
  input  logic [DATA_W-1:0]  reg_src1_data,
  input  logic [DATA_W-1:0]  imm_data,
  input  logic               imm_data_vld,
  output logic [DATA_W-1:0]  reg_wr_data,
  output logic [SEL_W-1:0]   reg_wr_sel,
  output logic               reg_wr_en,
  execute_mc_if.master       mem,
  output logic               pc_branch,
  output logic               stall,
  output logic [7:0]         sr,
  output mul_state_e         mul_state
);

  op_e                 ctrl_q;
  logic                en_q;
  logic [SEL_W-1:0]    dst_reg_q;
  logic [ADDR_W-1:0]   dst_addr_q;

  logic [DATA_W-1:0]   op_a, op_b, res;
  logic [DATA_W:0]     sum, diff;
  logic                carry, upd_flags, clr_flags, mem_rd, mem_wr;
  logic                mul_start, mul_done;
  logic [2*DATA_W-1:0] mul_product;

  // Debug print inputs are only meaningful in simulation models.
  logic unused_dbg;
  assign unused_dbg = ^{print_en, cycle_counter};

  // Stage-1 pipeline registers, frozen while the multiplier is busy.
  always_ff @(posedge clk) begin
    if (reset_) begin
      ctrl_q     <= OP_NOP;
      en_q       <= 1'b0;
      dst_reg_q  <= '0;
      dst_addr_q <= '0;
    end else if (!stall) begin
      ctrl_q     <= op_e'(exec_ctrl);
      en_q       <= execute_en;
      dst_reg_q  <= dst_reg;
      dst_addr_q <= dst_addr;
    end
  end

  assign mul_start = MUL_EN && en_q && (ctrl_q == OP_MUL);

  mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .reset_  (reset_),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .busy    (stall),
    .done    (mul_done),
    .product (mul_product),
    .state   (mul_state)
  );

  // Stage-1 datapath: result, carry and strobes for the op in stage 1.
  always_comb begin
    op_a      = reg_src0_data;
    op_b      = imm_data_vld ? imm_data : reg_src1_data;
    sum       = {1'b0, op_a} + {1'b0, op_b};
    diff      = {1'b0, op_a} - {1'b0, op_b};
    res       = '0;
    carry     = 1'b0;
    upd_flags = 1'b0;
    clr_flags = 1'b0;
    reg_wr_en = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    if (en_q) begin
      case (ctrl_q)
        OP_ADD: begin res = sum[DATA_W-1:0];  carry = sum[DATA_W];  upd_flags = 1'b1; reg_wr_en = 1'b1; end
        OP_SUB: begin res = diff[DATA_W-1:0]; carry = diff[DATA_W]; upd_flags = 1'b1; reg_wr_en = 1'b1; end
        OP_CMP: begin res = diff[DATA_W-1:0]; carry = diff[DATA_W]; upd_flags = 1'b1; end
        OP_OR:  begin res = op_a | op_b; upd_flags = 1'b1; reg_wr_en = 1'b1; end
        OP_AND: begin res = op_a & op_b; upd_flags = 1'b1; reg_wr_en = 1'b1; end
        OP_XOR: begin res = op_a ^ op_b; upd_flags = 1'b1; reg_wr_en = 1'b1; end
        OP_SHL: begin res = {op_a[DATA_W-2:0], 1'b0}; carry = op_a[DATA_W-1]; upd_flags = 1'b1; reg_wr_en = 1'b1; end
        OP_SHR: begin res = {1'b0, op_a[DATA_W-1:1]}; carry = op_a[0];        upd_flags = 1'b1; reg_wr_en = 1'b1; end
        OP_MEM_RD: begin mem_rd = 1'b1; reg_wr_en = 1'b1; end
        OP_MEM_WR: mem_wr = 1'b1;
        OP_JMP, OP_CALL, OP_RET: clr_flags = 1'b1;
        OP_MUL: begin
          if (MUL_EN && mul_done) begin
            res       = mul_product[DATA_W-1:0];
            carry     = |mul_product[2*DATA_W-1:DATA_W];
            upd_flags = 1'b1;
            reg_wr_en = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign reg_wr_data        = mem_rd ? mem.d_mem_data_in : res;
  assign reg_wr_sel         = dst_reg_q;
  assign mem.d_mem_addr     = dst_addr_q;
  assign mem.d_mem_data_out = op_a;
  assign mem.d_mem_rd       = mem_rd;
  assign mem.d_mem_wr       = mem_wr;
  assign mem.d_mem_en       = mem_rd | mem_wr;

  // Branches resolve from stage 0 but never while the stage is held.
  assign pc_branch = (exec_ctrl == OP_JMP) && execute_en && !stall;

  // Status register: full update on results, partial clear on control flow.
  always_ff @(posedge clk) begin
    if (reset_) begin
      sr <= '0;
    end else if (upd_flags) begin
      sr[SR_C]     <= carry;
      sr[SR_STOVF] <= 1'b0;
      sr[SR_NZ]    <= |res;
      sr[SR_Z]     <= ~|res;
      sr[SR_N]     <= res[DATA_W-1];
      sr[7:6]      <= 2'b00;
    end else if (clr_flags) begin
      sr[3:0]  <= 4'b0000;
      sr[SR_N] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_mc.sv
// Bench for execute_mc: a table of single-cycle ops on an 8-bit instance,
// hand-written multiply/branch/reset sequences, and a 16-bit instance.
module tb_execute_mc;
  import execute_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_;
  logic [31:0] cyc = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 8-bit DUT ----------------
  logic        execute_en, imm_data_vld;
  logic [3:0]  exec_ctrl;
  logic [1:0]  dst_reg;
  logic [11:0] dst_addr;
  logic [7:0]  reg_src0_data, reg_src1_data, imm_data;
  logic [7:0]  reg_wr_data;
  logic [1:0]  reg_wr_sel;
  logic        reg_wr_en, pc_branch, stall;
  logic [7:0]  sr;
  mul_state_e  st8;

  execute_mc_if #(.DATA_W(8), .ADDR_W(12)) mem8 ();

  execute_mc #(.DATA_W(8), .ADDR_W(12), .SEL_W(2), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset_(reset_), .print_en(1'b0), .cycle_counter(cyc),
    .execute_en(execute_en), .exec_ctrl(exec_ctrl), .dst_reg(dst_reg),
    .dst_addr(dst_addr), .reg_src0_data(reg_src0_data),
    .reg_src1_data(reg_src1_data), .imm_data(imm_data),
    .imm_data_vld(imm_data_vld), .reg_wr_data(reg_wr_data),
    .reg_wr_sel(reg_wr_sel), .reg_wr_en(reg_wr_en), .mem(mem8),
    .pc_branch(pc_branch), .stall(stall), .sr(sr), .mul_state(st8)
  );

  // ---------------- 16-bit DUT ----------------
  logic        w_en, w_vld;
  logic [3:0]  w_ctrl;
  logic [1:0]  w_dst;
  logic [11:0] w_addr;
  logic [15:0] w_a, w_b, w_imm, w_wr_data;
  logic [1:0]  w_wr_sel;
  logic        w_wr_en, w_pc, w_stall;
  logic [7:0]  w_sr;
  mul_state_e  st16;

  execute_mc_if #(.DATA_W(16), .ADDR_W(12)) mem16 ();

  execute_mc #(.DATA_W(16), .ADDR_W(12), .SEL_W(2), .MUL_EN(1'b1)) dut16 (
    .clk(clk), .reset_(reset_), .print_en(1'b0), .cycle_counter(cyc),
    .execute_en(w_en), .exec_ctrl(w_ctrl), .dst_reg(w_dst),
    .dst_addr(w_addr), .reg_src0_data(w_a), .reg_src1_data(w_b),
    .imm_data(w_imm), .imm_data_vld(w_vld), .reg_wr_data(w_wr_data),
    .reg_wr_sel(w_wr_sel), .reg_wr_en(w_wr_en), .mem(mem16),
    .pc_branch(w_pc), .stall(w_stall), .sr(w_sr), .mul_state(st16)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [9:0] exp_q[$];
  logic [9:0] sb_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every 8-bit writeback must match the next expected {sel,data}.
  always @(negedge clk) begin
    if (reg_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected_wr: got sel %0d data %0h, want no write", reg_wr_sel, reg_wr_data);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_wb", 32'({reg_wr_sel, reg_wr_data}), 32'(sb_e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

  // ---------------- table vectors ----------------
  typedef struct {
    op_e        op;
    logic [7:0] a;
    logic [7:0] b;
    logic       imm;
    logic [11:0] addr;
    logic [7:0] mem_in;
    logic       wr;
    logic [7:0] data;
    logic [2:0] mem;  // {en, rd, wr}
    logic [7:0] sr;
  } vec_t;

  vec_t vecs[14];

  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0] sel;
    sel = idx[1:0];
    @(posedge clk); #1;
    execute_en = 1'b1; exec_ctrl = v.op; dst_reg = sel; dst_addr = v.addr;
    @(negedge clk);
    check("vec_pc_branch", 32'(pc_branch), 32'(v.op == OP_JMP));
    if (v.wr) exp_q.push_back({sel, v.data});
    @(posedge clk); #1;
    execute_en = 1'b0; exec_ctrl = OP_NOP;
    reg_src0_data = v.a; imm_data_vld = v.imm;
    reg_src1_data = v.imm ? ~v.b : v.b;
    imm_data      = v.imm ? v.b : ~v.b;
    mem8.d_mem_data_in = v.mem_in;
    @(negedge clk);
    check("vec_wr_en", 32'(reg_wr_en), 32'(v.wr));
    check("vec_mem_strobes", 32'({mem8.d_mem_en, mem8.d_mem_rd, mem8.d_mem_wr}), 32'(v.mem));
    check("vec_mem_addr", 32'(mem8.d_mem_addr), 32'(v.addr));
    check("vec_mem_dout", 32'(mem8.d_mem_data_out), 32'(v.a));
    @(posedge clk); #1;
    @(negedge clk);
    check("vec_sr", 32'(sr), 32'(v.sr));
  endtask

  int n, cnt;

  initial begin
    reset_ = 1'b1;
    execute_en = 1'b0; exec_ctrl = OP_NOP; dst_reg = '0; dst_addr = '0;
    reg_src0_data = '0; reg_src1_data = '0; imm_data = '0; imm_data_vld = 1'b0;
    mem8.d_mem_data_in = '0;
    w_en = 1'b0; w_ctrl = OP_NOP; w_dst = 2'd1; w_addr = '0;
    w_a = '0; w_b = '0; w_imm = '0; w_vld = 1'b0;
    mem16.d_mem_data_in = '0;

    vecs[0]  = '{OP_ADD,    8'hF0, 8'h20, 1'b1, 12'h010, 8'h00, 1'b1, 8'h10, 3'b000, 8'h05};
    vecs[1]  = '{OP_SUB,    8'h05, 8'h05, 1'b0, 12'h011, 8'h00, 1'b1, 8'h00, 3'b000, 8'h08};
    vecs[2]  = '{OP_CMP,    8'h03, 8'h05, 1'b0, 12'h012, 8'h00, 1'b0, 8'h00, 3'b000, 8'h25};
    vecs[3]  = '{OP_MEM_WR, 8'hA5, 8'h00, 1'b0, 12'h123, 8'h00, 1'b0, 8'h00, 3'b101, 8'h25};
    vecs[4]  = '{OP_MEM_RD, 8'h00, 8'h00, 1'b0, 12'h456, 8'h3C, 1'b1, 8'h3C, 3'b110, 8'h25};
    vecs[5]  = '{OP_OR,     8'h0F, 8'hF0, 1'b1, 12'h013, 8'h00, 1'b1, 8'hFF, 3'b000, 8'h24};
    vecs[6]  = '{OP_AND,    8'hF0, 8'h0F, 1'b0, 12'h014, 8'h00, 1'b1, 8'h00, 3'b000, 8'h08};
    vecs[7]  = '{OP_XOR,    8'h3C, 8'h0F, 1'b0, 12'h015, 8'h00, 1'b1, 8'h33, 3'b000, 8'h04};
    vecs[8]  = '{OP_SHL,    8'h81, 8'h00, 1'b0, 12'h016, 8'h00, 1'b1, 8'h02, 3'b000, 8'h05};
    vecs[9]  = '{OP_SHR,    8'h02, 8'h00, 1'b0, 12'h017, 8'h00, 1'b1, 8'h01, 3'b000, 8'h04};
    vecs[10] = '{OP_JMP,    8'h00, 8'h00, 1'b0, 12'h018, 8'h00, 1'b0, 8'h00, 3'b000, 8'h00};
    vecs[11] = '{OP_ADD,    8'h7F, 8'h01, 1'b0, 12'h019, 8'h00, 1'b1, 8'h80, 3'b000, 8'h24};
    vecs[12] = '{OP_SUB,    8'h00, 8'h01, 1'b1, 12'h01A, 8'h00, 1'b1, 8'hFF, 3'b000, 8'h25};
    vecs[13] = '{OP_NOP,    8'h55, 8'hAA, 1'b0, 12'h01B, 8'h00, 1'b0, 8'h00, 3'b000, 8'h25};

    repeat (3) @(posedge clk);
    #1 reset_ = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_wr_en", 32'(reg_wr_en), 32'd0);
    check("rst_mem_en", 32'({mem8.d_mem_en, mem8.d_mem_rd, mem8.d_mem_wr}), 32'd0);
    check("rst_pc_branch", 32'(pc_branch), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_sr", 32'(sr), 32'd0);
    check("rst_state", 32'(st8), 32'(MUL_IDLE));
    check("rst16_stall", 32'(w_stall), 32'd0);
    check("rst16_sr", 32'(w_sr), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // MUL 0x10 * 0x11 with a JMP waiting in stage 0
    @(posedge clk); #1;
    execute_en = 1'b1; exec_ctrl = OP_MUL; dst_reg = 2'd2;
    @(posedge clk); #1;
    exec_ctrl = OP_JMP; dst_reg = 2'd0;
    reg_src0_data = 8'h10; reg_src1_data = 8'h11; imm_data = 8'hEE; imm_data_vld = 1'b0;
    exp_q.push_back({2'd2, 8'h10});
    n = 0;
    @(negedge clk);
    while (stall === 1'b1 && n < 40) begin
      n++;
      check("mul_jmp_held", 32'(pc_branch), 32'd0);
      @(posedge clk); #1;
      reg_src0_data = 8'($urandom_range(0, 255));
      reg_src1_data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    check("mul_stall_len", 32'(n), 32'd8);
    check("mul_wb_en", 32'(reg_wr_en), 32'd1);
    check("jmp_after_stall", 32'(pc_branch), 32'd1);
    @(posedge clk); #1;
    execute_en = 1'b0; exec_ctrl = OP_NOP;
    @(negedge clk);
    check("mul_sr", 32'(sr), 32'h05);
    @(posedge clk); #1;
    @(negedge clk);
    check("jmp_clears_sr", 32'(sr), 32'h00);

    // Back-to-back MULs: 3*5 then 7*9, second held in stage 0
    @(posedge clk); #1;
    execute_en = 1'b1; exec_ctrl = OP_MUL; dst_reg = 2'd1;
    @(posedge clk); #1;
    dst_reg = 2'd3; reg_src0_data = 8'h03; reg_src1_data = 8'h05;
    exp_q.push_back({2'd1, 8'h0F});
    exp_q.push_back({2'd3, 8'h3F});
    n = 0;
    @(negedge clk);
    while (stall === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
      reg_src0_data = 8'($urandom_range(0, 255));
      reg_src1_data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    check("b2b_first_len", 32'(n), 32'd8);
    @(posedge clk); #1;
    execute_en = 1'b0; exec_ctrl = OP_NOP;
    reg_src0_data = 8'h07; reg_src1_data = 8'h09;
    @(negedge clk);
    check("b2b_no_gap", 32'(stall), 32'd1);
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
      reg_src0_data = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    check("b2b_second_len", 32'(n), 32'd8);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_sr", 32'(sr), 32'h04);

    // Reset during the third busy cycle aborts the multiply
    @(posedge clk); #1;
    execute_en = 1'b1; exec_ctrl = OP_MUL; dst_reg = 2'd3;
    @(posedge clk); #1;
    execute_en = 1'b0; exec_ctrl = OP_NOP;
    reg_src0_data = 8'h0F; reg_src1_data = 8'h0F;
    @(negedge clk);
    check("abort_busy1", 32'(stall), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_ = 1'b1;
    @(negedge clk);
    check("abort_busy3", 32'(stall), 32'd1);
    @(posedge clk); #1;
    reset_ = 1'b0;
    @(negedge clk);
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_sr", 32'(sr), 32'h00);
    check("abort_state", 32'(st8), 32'(MUL_IDLE));
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (reg_wr_en !== 1'b0) cnt++;
    end
    check("abort_no_wb", 32'(cnt), 32'd0);

    // 16-bit instance: MUL 0x1234 * 0x0100
    @(posedge clk); #1;
    w_en = 1'b1; w_ctrl = OP_MUL;
    @(posedge clk); #1;
    w_en = 1'b0; w_ctrl = OP_NOP; w_a = 16'h1234; w_b = 16'h0100;
    n = 0;
    @(negedge clk);
    while (w_stall === 1'b1 && n < 60) begin
      n++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    check("mul16_stall_len", 32'(n), 32'd16);
    check("mul16_wr_en", 32'(w_wr_en), 32'd1);
    check("mul16_data", 32'(w_wr_data), 32'h3400);
    @(posedge clk); #1;
    @(negedge clk);
    check("mul16_sr", 32'(w_sr), 32'h05);

    // 16-bit SHR of 1: result zero, carry out of LSB
    @(posedge clk); #1;
    w_en = 1'b1; w_ctrl = OP_SHR;
    @(posedge clk); #1;
    w_en = 1'b0; w_ctrl = OP_NOP; w_a = 16'h0001;
    @(negedge clk);
    check("shr16_wr_en", 32'(w_wr_en), 32'd1);
    check("shr16_data", 32'(w_wr_data), 32'h0000);
    @(posedge clk); #1;
    @(negedge clk);
    check("shr16_sr", 32'(w_sr), 32'h09);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
